// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch memory bridge.
// FSM state encoding and fetch block geometry.
package ifu_pkg;

   localparam int FETCH_W     = 128;
   localparam int FETCH_BYTES = FETCH_W / 8;
   localparam int BLK_OFF_W   = $clog2(FETCH_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ifu_mem_bridge.sv
// Bridges pc_ctrl fetch requests to a single-outstanding memory read port.
// Handles redirects by withdrawing or draining, and flags stuck fetches.
module ifu_mem_bridge
   import ifu_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = FETCH_W,
   parameter int TIMEOUT = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pc_index_valid,
   input  logic [ADDR_W-1:0] pc_index,
   output logic              pc_index_ready,
   output logic              pc_operation_done,
   output logic [DATA_W-1:0] pc_read_inst,
   input  logic              redirect_valid,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              fetch_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] BLK_MASK =
      ~ADDR_W'((1 << BLK_OFF_W) - 1);

   ifu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              tmo_q, tmo_d;
   logic              accept;

   // Ready is masked during reset so every output reads low while held.
   assign pc_index_ready    = reset_n & (state_q == IDLE) & ~redirect_valid;
   assign accept            = pc_index_valid & pc_index_ready;
   assign mem_req_valid     = (state_q == REQ);
   assign mem_req_addr      = addr_q;
   assign pc_read_inst      = data_q;
   assign pc_operation_done = done_q;
   assign fetch_timeout     = tmo_q;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = pc_index & BLK_MASK;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d = redirect_valid ? DROP : WAIT;
               cnt_d   = '0;
            end else if (redirect_valid) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (mem_resp_valid) begin
               state_d = IDLE;
               if (!redirect_valid) begin
                  data_d = mem_resp_data;
                  done_d = 1'b1;
               end
            end else if (redirect_valid) begin
               state_d = DROP;
               cnt_d   = '0;
            end
         end
         DROP: begin
            cnt_d = cnt_inc;
            if (mem_resp_valid && !redirect_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      tmo_d = tmo_q | (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_ifu_mem_bridge.sv
// Directed self-checking bench for ifu_mem_bridge.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_ifu_mem_bridge;
   import ifu_pkg::*;

   localparam int AW = 64;
   localparam int DW = FETCH_W;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          pc_index_valid = 1'b0;
   logic [AW-1:0] pc_index = '0;
   logic          pc_index_ready;
   logic          pc_operation_done;
   logic [DW-1:0] pc_read_inst;
   logic          redirect_valid = 1'b0;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic [AW-1:0] mem_req_addr;
   logic          mem_resp_valid = 1'b0;
   logic [DW-1:0] mem_resp_data = '0;
   logic          fetch_timeout;

   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;

   ifu_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .pc_index_valid(pc_index_valid), .pc_index(pc_index),
      .pc_index_ready(pc_index_ready),
      .pc_operation_done(pc_operation_done),
      .pc_read_inst(pc_read_inst),
      .redirect_valid(redirect_valid),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .fetch_timeout(fetch_timeout)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (mem_req_valid && mem_req_ready) hs_cnt++;

   task automatic nxt();
      @(negedge clock);
   endtask

   task automatic accept_fetch(input logic [AW-1:0] a);
      pc_index_valid = 1'b1;
      pc_index = a;
      nxt();
      pc_index_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", mem_req_valid); end
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", pc_operation_done); end
      checks++; if (pc_read_inst !== '0) begin failures++; $display("FAIL rst_inst got=%h exp=0", pc_read_inst); end
      checks++; if (mem_req_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_req_addr); end
      checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL rst_tmo got=%0b exp=0", fetch_timeout); end
      nxt(); nxt();
      reset_n = 1'b1; #1;
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", pc_index_ready); end
   endtask

   task automatic test_basic();
      nxt();
      pc_index_valid = 1'b1; pc_index = 64'h8000_000C; #1;
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", pc_index_ready); end
      nxt();
      pc_index_valid = 1'b0; mem_req_ready = 1'b1; #1;
      checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL basic_req_valid got=%0b exp=1", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL basic_addr got=%h exp=80000000", mem_req_addr); end
      nxt();
      mem_req_ready = 1'b0; #1;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_wait_valid got=%0b exp=0", mem_req_valid); end
      nxt();
      nxt();
      mem_resp_valid = 1'b1; mem_resp_data = {16{8'hA5}}; #1;
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL basic_early_done got=%0b exp=0", pc_operation_done); end
      nxt();
      mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
      checks++; if (pc_operation_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", pc_operation_done); end
      checks++; if (pc_read_inst !== {16{8'hA5}}) begin failures++; $display("FAIL basic_inst got=%h exp=a5..", pc_read_inst); end
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL basic_idle got=%0b exp=1", pc_index_ready); end
      nxt(); #1;
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%0b exp=0", pc_operation_done); end
      checks++; if (pc_read_inst !== {16{8'hA5}}) begin failures++; $display("FAIL basic_hold got=%h exp=a5..", pc_read_inst); end
   endtask

   task automatic test_backpressure();
      int hs0;
      hs0 = hs_cnt;
      accept_fetch(64'h1234_5678_9ABC_DEF7);
      for (int i = 0; i < 5; i++) begin
         mem_req_ready = 1'b0; #1;
         checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, mem_req_valid); end
         checks++; if (mem_req_addr !== 64'h1234_5678_9ABC_DEF0) begin failures++; $display("FAIL bp_addr[%0d] got=%h exp=123456789abcdef0", i, mem_req_addr); end
         nxt();
      end
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready = 1'b0; #1;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_drop_valid got=%0b exp=0", mem_req_valid); end
      checks++; if (hs_cnt - hs0 !== 1) begin failures++; $display("FAIL bp_single got=%0d exp=1", hs_cnt - hs0); end
      mem_resp_valid = 1'b1; mem_resp_data = {8{16'h1111}};
      nxt();
      mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b1) begin failures++; $display("FAIL bp_done got=%0b exp=1", pc_operation_done); end
      checks++; if (pc_read_inst !== {8{16'h1111}}) begin failures++; $display("FAIL bp_inst got=%h exp=1111..", pc_read_inst); end
      nxt();
   endtask

   task automatic test_redirect_wait();
      accept_fetch(64'h40);
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready = 1'b0; redirect_valid = 1'b1; #1;
      checks++; if (pc_index_ready !== 1'b0) begin failures++; $display("FAIL rw_ready_redir got=%0b exp=0", pc_index_ready); end
      nxt();
      redirect_valid = 1'b0;
      nxt();
      nxt();
      mem_resp_valid = 1'b1; mem_resp_data = {4{32'hDEAD_BEEF}}; #1;
      checks++; if (pc_index_ready !== 1'b0) begin failures++; $display("FAIL rw_drop_busy got=%0b exp=0", pc_index_ready); end
      nxt();
      mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL rw_no_done got=%0b exp=0", pc_operation_done); end
      checks++; if (pc_read_inst !== {8{16'h1111}}) begin failures++; $display("FAIL rw_inst got=%h exp=1111..", pc_read_inst); end
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL rw_ready got=%0b exp=1", pc_index_ready); end
      accept_fetch(64'h5A);
      #1;
      checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rw_next_valid got=%0b exp=1", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h50) begin failures++; $display("FAIL rw_next_addr got=%h exp=50", mem_req_addr); end
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = {8{16'h2222}};
      nxt();
      mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b1) begin failures++; $display("FAIL rw_next_done got=%0b exp=1", pc_operation_done); end
      checks++; if (pc_read_inst !== {8{16'h2222}}) begin failures++; $display("FAIL rw_next_inst got=%h exp=2222..", pc_read_inst); end
      nxt();
   endtask

   task automatic test_simul_redirect();
      accept_fetch(64'h100);
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready = 1'b0; redirect_valid = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = {8{16'h3333}};
      nxt();
      redirect_valid = 1'b0; mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL sim_no_done got=%0b exp=0", pc_operation_done); end
      checks++; if (pc_read_inst !== {8{16'h2222}}) begin failures++; $display("FAIL sim_inst got=%h exp=2222..", pc_read_inst); end
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL sim_idle got=%0b exp=1", pc_index_ready); end
      nxt();
   endtask

   task automatic test_redirect_req();
      mem_resp_valid = 1'b1; mem_resp_data = {8{16'h9999}};
      nxt();
      mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL idle_resp_done got=%0b exp=0", pc_operation_done); end
      checks++; if (pc_read_inst !== {8{16'h2222}}) begin failures++; $display("FAIL idle_resp_inst got=%h exp=2222..", pc_read_inst); end
      accept_fetch(64'h200);
      redirect_valid = 1'b1; #1;
      checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rq_valid got=%0b exp=1", mem_req_valid); end
      nxt();
      redirect_valid = 1'b0; #1;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rq_withdraw got=%0b exp=0", mem_req_valid); end
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL rq_idle got=%0b exp=1", pc_index_ready); end
      accept_fetch(64'h300);
      mem_req_ready = 1'b1; redirect_valid = 1'b1;
      nxt();
      mem_req_ready = 1'b0; #1;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rqd_valid got=%0b exp=0", mem_req_valid); end
      nxt();
      redirect_valid = 1'b0; #1;
      checks++; if (pc_index_ready !== 1'b0) begin failures++; $display("FAIL rqd_stay got=%0b exp=0", pc_index_ready); end
      mem_resp_valid = 1'b1; mem_resp_data = {8{16'h4444}};
      nxt();
      mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL rqd_no_done got=%0b exp=0", pc_operation_done); end
      checks++; if (pc_read_inst !== {8{16'h2222}}) begin failures++; $display("FAIL rqd_inst got=%h exp=2222..", pc_read_inst); end
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL rqd_idle got=%0b exp=1", pc_index_ready); end
      nxt();
   endtask

   task automatic test_timeout();
      accept_fetch(64'h400);
      mem_req_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         nxt();
         mem_req_ready = 1'b0; #1;
         checks++; if (fetch_timeout !== (k >= 8)) begin failures++; $display("FAIL tmo[%0d] got=%0b exp=%0b", k, fetch_timeout, k >= 8); end
      end
      checks++; if (pc_index_ready !== 1'b0) begin failures++; $display("FAIL tmo_waiting got=%0b exp=0", pc_index_ready); end
      mem_resp_valid = 1'b1; mem_resp_data = {8{16'h5555}};
      nxt();
      mem_resp_valid = 1'b0; #1;
      checks++; if (pc_operation_done !== 1'b1) begin failures++; $display("FAIL tmo_done got=%0b exp=1", pc_operation_done); end
      checks++; if (fetch_timeout !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0b exp=1", fetch_timeout); end
      nxt();
   endtask

   task automatic test_reset_mid();
      accept_fetch(64'h500);
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", mem_req_valid); end
      checks++; if (mem_req_addr !== '0) begin failures++; $display("FAIL rm_addr got=%h exp=0", mem_req_addr); end
      checks++; if (pc_read_inst !== '0) begin failures++; $display("FAIL rm_inst got=%h exp=0", pc_read_inst); end
      checks++; if (pc_operation_done !== 1'b0) begin failures++; $display("FAIL rm_done got=%0b exp=0", pc_operation_done); end
      checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL rm_tmo got=%0b exp=0", fetch_timeout); end
      nxt();
      reset_n = 1'b1; #1;
      checks++; if (pc_index_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%0b exp=1", pc_index_ready); end
      nxt(); #1;
      checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL rm_tmo_after got=%0b exp=0", fetch_timeout); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_simul_redirect();
      test_redirect_req();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_mem_bridge.md
IFU_MEM_BRIDGE -- requirements
Module: ifu_mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, 64, fetch address width.
REQ-002 SHALL have parameter DATA_W, 128, fetch block width (16 bytes).
REQ-003 SHALL have parameter TIMEOUT, 1024, cycles allowed from memory request issue to response.
REQ-004 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pc_index_valid  in  1  fetch request from pc_ctrl.
REQ-007 SHALL have port pc_index  in  ADDR_W  fetch byte address.
REQ-008 SHALL have port pc_index_ready  out  1  request accepted this cycle.
REQ-009 SHALL have port pc_operation_done  out  1  one-cycle pulse: pc_read_inst valid.
REQ-010 SHALL have port pc_read_inst  out  DATA_W  fetched 128-bit block.
REQ-011 SHALL have port redirect_valid  in  1  flush; discard any in-flight fetch.
REQ-012 SHALL have port mem_req_valid  out  1  memory read request.
REQ-013 SHALL have port mem_req_ready  in  1  memory accepts request.
REQ-014 SHALL have port mem_req_addr  out  ADDR_W  16-byte-aligned read address.
REQ-015 SHALL have port mem_resp_valid  in  1  read data returned.
REQ-016 SHALL have port mem_resp_data  in  DATA_W  read data.
REQ-017 SHALL have port fetch_timeout  out  1  sticky error flag.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, DROP; one outstanding memory request maximum.
REQ-019 SHALL drive pc_index_ready = (state==IDLE) & ~redirect_valid, combinationally.
REQ-020 SHALL, on pc_index_valid & pc_index_ready, latch {pc_index[ADDR_W-1:4],4'b0} into mem_req_addr and go IDLE->REQ.
REQ-021 SHALL assert mem_req_valid only in REQ, holding mem_req_addr stable until mem_req_ready.
REQ-022 SHALL go REQ->WAIT on mem_req_valid & mem_req_ready with no redirect.
REQ-023 SHALL, in WAIT on mem_resp_valid with no redirect, register mem_resp_data into pc_read_inst, pulse pc_operation_done next cycle (1 cycle latency), and return to IDLE.
REQ-024 SHALL hold pc_read_inst unchanged between done pulses.
REQ-025 SHALL, on redirect in REQ without mem_req_ready, withdraw request and go IDLE.
REQ-026 SHALL, on redirect in REQ with mem_req_ready the same cycle, go DROP.
REQ-027 SHALL, on redirect in WAIT without mem_resp_valid, go DROP.
REQ-028 SHALL, on redirect in WAIT with mem_resp_valid the same cycle, discard data, no done, go IDLE.
REQ-029 SHALL, in DROP, discard the next mem_resp_valid without done or pc_read_inst update and go IDLE; redirect in DROP stays in DROP.
REQ-030 SHALL ignore mem_resp_valid in IDLE and REQ.
REQ-031 SHALL run a counter, cleared on entering WAIT or DROP, incrementing each WAIT/DROP cycle, saturating at TIMEOUT.
REQ-032 SHALL set fetch_timeout when the counter reaches TIMEOUT; it stays set until reset; FSM keeps waiting.

Reset
REQ-033 SHALL, on reset_n low, immediately force state IDLE, pc_operation_done 0, pc_read_inst 0, mem_req_addr 0, counter 0, fetch_timeout 0.
REQ-034 SHALL abandon any in-flight request on reset mid-operation; memory is reset concurrently.

Structure
REQ-035 SHALL place FSM state enum (2-bit) and fetch block width constant in shared package ifu_pkg.
REQ-036 SHALL be a single module; no sub-module.

Verification
REQ-037 SHALL test basic fetch: pc_index=0x8000_000C, mem_req_ready same cycle, response 3 cycles later data=0xA5..A5 -> mem_req_addr=0x8000_0000, done pulse 1 cycle after response, pc_read_inst=0xA5..A5.
REQ-038 SHALL test backpressure: mem_req_ready low 5 cycles -> mem_req_valid and addr held stable 5 cycles, single request issued.
REQ-039 SHALL test redirect in WAIT: redirect 1 cycle after issue, response 4 cycles later -> no done, pc_read_inst unchanged, next request accepted after response.
REQ-040 SHALL test simultaneous redirect and mem_resp_valid in WAIT -> no done, state IDLE next cycle.
REQ-041 SHALL test timeout: TIMEOUT=8, no response -> fetch_timeout rises 8 cycles after entering WAIT, stays high until reset_n low.
REQ-042 SHALL test reset mid-fetch: reset_n low in WAIT -> all outputs 0 immediately, pc_index_ready=1 after release.
